// File: rtl/mult_int7b_pkg.sv
// Shared widths, default coefficient and data types for the int7 x const multiplier.
package mult_int7b_pkg;
  localparam int BIT_WIDTH   = 7;
  localparam int COEFF_WIDTH = 8;
  localparam int OUT_WIDTH   = BIT_WIDTH + COEFF_WIDTH;
  localparam int TRUNC_BITS  = 3;

  localparam logic signed [COEFF_WIDTH-1:0] DEFAULT_COEFF = 8'sd93;

  typedef logic signed [BIT_WIDTH-1:0] inp_t;
  typedef logic signed [OUT_WIDTH-1:0] prod_t;
endpackage

// File: rtl/mult_pp_array.sv
// Combinational shift-add partial-product array: inp * COEFF, two's complement.
// With APPROX_TRUNC_EN defined the product is floored to a multiple of 2^TRUNC_BITS.
module mult_pp_array
  import mult_int7b_pkg::*;
#(
  parameter logic signed [COEFF_WIDTH-1:0] COEFF = DEFAULT_COEFF
) (
  input  inp_t  inp,
  output prod_t prod
);

  localparam prod_t COEFF_EXT = prod_t'(COEFF);

  prod_t pp  [BIT_WIDTH];
  prod_t acc [BIT_WIDTH+1];

  assign acc[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < BIT_WIDTH; gi++) begin : g_pp
      assign pp[gi] = inp[gi] ? prod_t'(COEFF_EXT <<< gi) : '0;
      // The input sign bit carries weight -2^(BIT_WIDTH-1).
      if (gi == BIT_WIDTH - 1) begin : g_msb
        assign acc[gi+1] = acc[gi] - pp[gi];
      end else begin : g_lsb
        assign acc[gi+1] = acc[gi] + pp[gi];
      end
    end
  endgenerate

`ifdef APPROX_TRUNC_EN
  // Low columns survive only as carry sources, so the floor stays exact.
  assign prod = {acc[BIT_WIDTH][OUT_WIDTH-1:TRUNC_BITS], {TRUNC_BITS{1'b0}}};
`else
  assign prod = acc[BIT_WIDTH];
`endif

endmodule

// File: rtl/mult_int7b_const.sv
// Registered signed constant multiplier: out = inp * COEFF, one-cycle latency.
// Build option APPROX_TRUNC_EN clears the TRUNC_BITS product LSBs.
module mult_int7b_const
  import mult_int7b_pkg::*;
#(
  parameter logic signed [COEFF_WIDTH-1:0] COEFF = DEFAULT_COEFF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [BIT_WIDTH-1:0] inp,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out
);

  prod_t prod_next;
  prod_t out_reg;
  logic  out_valid_reg;

  mult_pp_array #(.COEFF(COEFF)) u_pp (
    .inp  (inp),
    .prod (prod_next)
  );

  // out only loads on valid input, so an unqualified inp never reaches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        out_reg <= prod_next;
      end
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mult_int7b_const.sv
// Directed bench for mult_int7b_const (default coefficient plus two swept coefficients).
// Expectations follow the APPROX_TRUNC_EN setting of the build.
module tb_mult_int7b_const;
  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic signed [6:0]  inp;
  logic               out_valid_a, out_valid_b, out_valid_c;
  logic signed [14:0] out_a, out_b, out_c;

  int checks = 0;
  int errors = 0;

  mult_int7b_const dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inp(inp),
    .out_valid(out_valid_a), .out(out_a)
  );

  mult_int7b_const #(.COEFF(8'sh80)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inp(inp),
    .out_valid(out_valid_b), .out(out_b)
  );

  mult_int7b_const #(.COEFF(-8'sd1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inp(inp),
    .out_valid(out_valid_c), .out(out_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [31:0] model(input int v, input int c);
    int p;
    p = v * c;
`ifdef APPROX_TRUNC_EN
    p = p & ~32'sd7;
`endif
    return p;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] x);
    in_valid = v;
    inp      = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    inp      = 7'sd5;

    // Held in reset while clocking valid data
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_out", 32'(out_a), 0);
      check("rst_valid", 32'(out_valid_a), 0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(out_valid_a), 0);
    check("post_rst_out", 32'(out_a), 0);

    // Basic back-to-back
    drive(1'b1, 7'sd1);
`ifdef APPROX_TRUNC_EN
    check("basic_one", 32'(out_a), 88);
`else
    check("basic_one", 32'(out_a), 93);
`endif
    check("basic_one_valid", 32'(out_valid_a), 1);
    drive(1'b1, 7'sd0);
    check("basic_zero", 32'(out_a), 0);
    check("basic_zero_valid", 32'(out_valid_a), 1);

    // Extremes
    drive(1'b1, -7'sd64);
    check("min_in", 32'(out_a), -5952);
    check("min_in_coeff_m128", 32'(out_b), 8192);
    drive(1'b1, 7'sd63);
`ifdef APPROX_TRUNC_EN
    check("max_in", 32'(out_a), 5856);
    check("max_in_coeff_m1", 32'(out_c), -64);
`else
    check("max_in", 32'(out_a), 5859);
    check("max_in_coeff_m1", 32'(out_c), -63);
`endif
    drive(1'b1, -7'sd1);
`ifdef APPROX_TRUNC_EN
    check("minus_one", 32'(out_a), -96);
`else
    check("minus_one", 32'(out_a), -93);
`endif

    // Valid gating with X on inp
    drive(1'b1, 7'sd10);
`ifdef APPROX_TRUNC_EN
    check("gate_load", 32'(out_a), 928);
`else
    check("gate_load", 32'(out_a), 930);
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 7'bx);
`ifdef APPROX_TRUNC_EN
      check("gate_hold", 32'(out_a), 928);
`else
      check("gate_hold", 32'(out_a), 930);
`endif
      check("gate_valid", 32'(out_valid_a), 0);
    end

    // Exhaustive back-to-back stream, all three coefficients
    for (int v = -64; v < 64; v++) begin
      drive(1'b1, 7'(v));
      check($sformatf("exh_a_%0d", v), 32'(out_a), model(v, 93));
      check($sformatf("exh_b_%0d", v), 32'(out_b), model(v, -128));
      check($sformatf("exh_c_%0d", v), 32'(out_c), model(v, -1));
      check($sformatf("exh_valid_%0d", v), 32'(out_valid_a), 1);
    end

    // Asynchronous reset in mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out_a), 0);
    check("async_rst_valid", 32'(out_valid_a), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("release_no_stale", 32'(out_valid_a), 0);
    drive(1'b1, 7'sd7);
    check("release_first", 32'(out_a), model(7, 93));
    check("release_first_valid", 32'(out_valid_a), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
